// File: rtl/tile_shifter_if.sv
// Handshake and board bus between the move pipeline controller and the tile slide stage.
interface tile_shifter_if #(
    parameter int W = 12,
    parameter int N = 4
);
    localparam int SW = $clog2(N) + 1;

    logic                          start;
    logic [3:0]                    direction;
    logic [N-1:0][N-1:0][W-1:0]    matrix;
    logic [N-1:0][N-1:0][W-1:0]    shifted_matrix;
    logic                          busy;
    logic                          done;
    logic                          moved;
    logic [SW-1:0]                 steps;

    modport master (
        output start, direction, matrix,
        input  shifted_matrix, busy, done, moved, steps
    );

    modport slave (
        input  start, direction, matrix,
        output shifted_matrix, busy, done, moved, steps
    );
endinterface

// File: rtl/tile_shifter.sv
// Slide stage of the 2048 move pipeline: compacts non-zero tiles toward one edge,
// one cell per clock, without merging.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | one compaction step per cycle until nothing moves
//   DONE  | final board reached; done pulses on the following cycle
module tile_shifter #(
    parameter int W = 12,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    tile_shifter_if.slave    bus
);
    localparam int SW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef logic [N-1:0][N-1:0][W-1:0] board_t;

    state_t        state_q, state_d;
    board_t        board_q, board_d, board_step;
    logic [3:0]    dir_q, dir_d;
    logic          moved_q, moved_d;
    logic [SW-1:0] steps_q, steps_d;
    logic          done_q, done_d;
    logic          any_move;
    logic          go_left, go_down, go_up, go_right;

    // Anything other than an exact one-hot code leaves every flag low, so no tile moves.
    assign go_left  = (dir_q == 4'b1000);
    assign go_down  = (dir_q == 4'b0100);
    assign go_up    = (dir_q == 4'b0010);
    assign go_right = (dir_q == 4'b0001);

    // A cell empties when its tile can advance; an empty cell takes the tile behind it.
    // Both decisions look only at the registered board, so each tile moves at most one cell.
    always_comb begin
        board_step = board_q;
        any_move   = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                logic         has_dst;
                logic         has_src;
                logic [W-1:0] dst;
                logic [W-1:0] src;
                has_dst = 1'b0;
                has_src = 1'b0;
                dst     = '0;
                src     = '0;
                if (go_down) begin
                    has_dst = (r > 0);
                    has_src = (r < N-1);
                    dst     = board_q[(r > 0) ? r-1 : 0][c];
                    src     = board_q[(r < N-1) ? r+1 : N-1][c];
                end else if (go_up) begin
                    has_dst = (r < N-1);
                    has_src = (r > 0);
                    dst     = board_q[(r < N-1) ? r+1 : N-1][c];
                    src     = board_q[(r > 0) ? r-1 : 0][c];
                end else if (go_left) begin
                    has_dst = (c < N-1);
                    has_src = (c > 0);
                    dst     = board_q[r][(c < N-1) ? c+1 : N-1];
                    src     = board_q[r][(c > 0) ? c-1 : 0];
                end else if (go_right) begin
                    has_dst = (c > 0);
                    has_src = (c < N-1);
                    dst     = board_q[r][(c > 0) ? c-1 : 0];
                    src     = board_q[r][(c < N-1) ? c+1 : N-1];
                end
                if (board_q[r][c] != '0 && has_dst && dst == '0) begin
                    board_step[r][c] = '0;
                    any_move         = 1'b1;
                end else if (board_q[r][c] == '0 && has_src && src != '0) begin
                    board_step[r][c] = src;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        dir_d   = dir_q;
        moved_d = moved_q;
        steps_d = steps_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    board_d = bus.matrix;
                    dir_d   = bus.direction;
                    moved_d = 1'b0;
                    steps_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (any_move) begin
                    board_d = board_step;
                    steps_d = steps_q + SW'(1);
                    moved_d = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            board_q <= '0;
            dir_q   <= '0;
            moved_q <= 1'b0;
            steps_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            dir_q   <= dir_d;
            moved_q <= moved_d;
            steps_q <= steps_d;
            done_q  <= done_d;
        end
    end

    assign bus.shifted_matrix = board_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = done_q;
    assign bus.moved          = moved_q;
    assign bus.steps          = steps_q;
endmodule

// File: tb/tb_tile_shifter.sv
// Directed bench for tile_shifter: hand-computed boards, step counts and done latency.
module tb_tile_shifter;
    localparam int W  = 12;
    localparam int N  = 4;
    localparam int SW = $clog2(N) + 1;

    typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    tile_shifter_if #(.W(W), .N(N)) bus ();

    tile_shifter #(.W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse sampled at edge 0; done is expected one sample after edge 2+steps.
    task automatic run(input string tag, input mat_t m, input logic [3:0] d,
                       input mat_t exp_m, input int exp_steps, input logic exp_moved);
        int done_at;
        bus.matrix    = m;
        bus.direction = d;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.matrix    = '1;
        bus.direction = 4'b0100;
        check({tag, "_busy"}, 256'(bus.busy), 256'(1'b1));
        done_at = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.done === 1'b1) begin
                done_at = k;
                break;
            end
        end
        check({tag, "_latency"}, 256'(done_at), 256'(2 + exp_steps));
        check({tag, "_board"}, 256'(bus.shifted_matrix), 256'(exp_m));
        check({tag, "_steps"}, 256'(bus.steps), 256'(exp_steps));
        check({tag, "_moved"}, 256'(bus.moved), 256'(exp_moved));
        tick();
        check({tag, "_done_pulse"}, 256'(bus.done), 256'(1'b0));
        check({tag, "_hold"}, 256'(bus.shifted_matrix), 256'(exp_m));
    endtask

    initial begin
        mat_t m, e;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.direction = 4'b0000;
        bus.matrix    = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_board", 256'(bus.shifted_matrix), 256'(0));
        check("rst_busy",  256'(bus.busy),  256'(0));
        check("rst_done",  256'(bus.done),  256'(0));
        check("rst_moved", 256'(bus.moved), 256'(0));
        check("rst_steps", 256'(bus.steps), 256'(0));
        tick();

        // DOWN: col0 {0,0,0,2} -> {2,0,0,0}
        m = '0; m[3][0] = 12'd2;
        e = '0; e[0][0] = 12'd2;
        run("down", m, 4'b0100, e, 3, 1'b1);

        // LEFT: row0 {2,0,4,0} -> {0,0,2,4}; row1 {0,5,0,7} -> {0,0,5,7}
        m = '0; m[0][0] = 12'd2; m[0][2] = 12'd4; m[1][1] = 12'd5; m[1][3] = 12'd7;
        e = '0; e[0][2] = 12'd2; e[0][3] = 12'd4; e[1][2] = 12'd5; e[1][3] = 12'd7;
        run("left", m, 4'b1000, e, 2, 1'b1);

        // UP: col1 {2,2,0,0} -> {0,0,2,2}, no merge
        m = '0; m[0][1] = 12'd2; m[1][1] = 12'd2;
        e = '0; e[2][1] = 12'd2; e[3][1] = 12'd2;
        run("up", m, 4'b0010, e, 3, 1'b1);

        // RIGHT: already compact against col 0
        m = '0;
        for (int r = 0; r < N; r++) m[r][0] = W'(r + 1);
        m[2][1] = 12'hABC;
        run("right_compact", m, 4'b0001, m, 0, 1'b0);

        // RIGHT with bit-exact copy of a wide value: row3 {0,0,0,FFF} -> {FFF,0,0,0}
        m = '0; m[3][3] = 12'hFFF;
        e = '0; e[3][0] = 12'hFFF;
        run("right_move", m, 4'b0001, e, 3, 1'b1);

        // Invalid directions leave the board alone
        m = '0; m[1][2] = 12'd8; m[3][0] = 12'd16;
        run("dir_0011", m, 4'b0011, m, 0, 1'b0);
        run("dir_0000", m, 4'b0000, m, 0, 1'b0);

        // Start while busy is ignored, then reset mid-SHIFT clears everything
        m = '0; m[3][0] = 12'd2;
        bus.matrix    = m;
        bus.direction = 4'b0100;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        tick();
        bus.matrix    = '0;
        bus.matrix[0][3] = 12'd9;
        bus.direction = 4'b0001;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        e = '0; e[1][0] = 12'd2;
        check("busy_ignore_board", 256'(bus.shifted_matrix), 256'(e));
        check("busy_ignore_steps", 256'(bus.steps), 256'(2));
        check("busy_ignore_busy",  256'(bus.busy),  256'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_board", 256'(bus.shifted_matrix), 256'(0));
        check("midrst_busy",  256'(bus.busy),  256'(0));
        check("midrst_done",  256'(bus.done),  256'(0));
        check("midrst_moved", 256'(bus.moved), 256'(0));
        check("midrst_steps", 256'(bus.steps), 256'(0));
        tick();
        tick();
        check("midrst_idle", 256'(bus.busy), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
